iopmp_check_arbiter: RTL and testbench
======================================

# iopmp_check_arbiter

Shares one IOPMP check port among the per-channel request paths. Up to `IOPMPNumChan` requesters each present an address, access type and RRID. The arbiter grants one requester at a time in round-robin order, drives the shared checker for a fixed number of cycles, registers the permission result, and returns it to the granted requester. It sits between `iopmp_req_handler_tlul` and `iopmp_array_top`, so a single checker instance can replace one checker per channel.

## Interface
- `IOPMPNumChan`, 3, number of requesters (≥1)
- `AddrWidth`, 34, check address width
- `RridWidth`, `SourceWidth`, requester ID width
- `CheckLatency`, 1, cycles the checker needs from stable inputs to a valid `chk_err_i` (≥1)
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `req_valid_i`  in  [IOPMPNumChan]  requester has a check pending
- `req_ready_o`  out  [IOPMPNumChan]  request accepted this cycle (one-hot or zero)
- `req_addr_i`  in  [IOPMPNumChan][AddrWidth]  address to check
- `req_type_i`  in  [IOPMPNumChan] `iopmp_req_e`  access type
- `req_rrid_i`  in  [IOPMPNumChan][RridWidth]  requester ID
- `rsp_valid_o`  out  [IOPMPNumChan]  one-cycle result pulse to the granted requester
- `rsp_err_o`  out  [IOPMPNumChan]  1 = permission denied; valid only with `rsp_valid_o`, otherwise 0
- `chk_valid_o`  out  1  shared checker inputs are valid
- `chk_addr_o`  out  AddrWidth  latched address
- `chk_type_o`  out  `iopmp_req_e`  latched type
- `chk_rrid_o`  out  RridWidth  latched RRID
- `chk_err_i`  in  1  checker verdict

## Operation
- FSM states are `IDLE`, `CHECK` and `RESP`.
- **IDLE**
  - If any `req_valid_i` is set, pick the first set index scanning upward from `rr_ptr`, wrapping at `IOPMPNumChan-1`→0.
  - Assert `req_ready_o[g]` combinationally in the same cycle.
  - Latch `g`, the address, type and RRID.
  - Load `cnt` with `CheckLatency-1` and go to `CHECK`.
  - If no request is pending, stay in `IDLE`.
- **CHECK**
  - Hold `chk_valid_o`=1 with the latched values.
  - If `cnt`==0, register `chk_err_i` into `err_q` and go to `RESP`; otherwise decrement `cnt`.
- **RESP**
  - Assert `rsp_valid_o[g]`=1 and `rsp_err_o[g]`=`err_q`.
  - Set `rr_ptr` to `(g+1) mod IOPMPNumChan`.
  - Go to `IDLE`.
- Requester handshake rules:
  - Each requester holds valid and payload stable until it sees `req_ready_o`.
  - It must not re-request until it has received its `rsp_valid_o`.
  - Signals on the non-granted channels are ignored.
- `req_ready_o` is zero in every state other than `IDLE`. A request arriving during `CHECK` or `RESP` waits.
- `chk_*` outputs are zero when `chk_valid_o`=0.
- `cnt` width is `$clog2(CheckLatency+1)`. `rr_ptr` and `g` width is `$clog2(IOPMPNumChan)`, minimum 1.

## Timing
- Reset (async assert, removal synchronous to `clk`) sets:
  - state `IDLE`, `rr_ptr`=0, `err_q`=0
  - all `req_ready_o`, `rsp_valid_o`, `rsp_err_o`, `chk_*` outputs to 0
- Reset mid-transaction discards the transaction with no response.
- Accept in cycle T. `chk_valid_o` is high in cycles T+1 … T+CheckLatency. `rsp_valid_o` is high in cycle T+CheckLatency+1.
- Throughput is one check per CheckLatency+2 cycles.
- Simultaneous requests: grant order is strictly round-robin, and every pending requester is served within `IOPMPNumChan` grants.
- A requester dropping `req_valid_i` before acceptance is legal; it is simply not granted.
- Single-requester configuration (`IOPMPNumChan`=1): `rr_ptr` stays at 0.

## Structure
- Add `iopmp_arb_state_e` (`IDLE`/`CHECK`/`RESP`) to `iopmp_pkg`. `iopmp_req_e` is reused from there.
- Sub-module `iopmp_rr_picker` is combinational. It takes the `req_valid_i` vector and `rr_ptr`, and produces the grant index plus an any-valid flag.

## Test plan
- **Single request:** ch1 requests addr 0x1000, read, `CheckLatency`=1, `chk_err_i`=0 → `req_ready_o`=3'b010 at T; `chk_valid_o`, `chk_addr_o`=0x1000 at T+1; `rsp_valid_o`=3'b010 with `rsp_err_o`=0 at T+2.
- **Denied:** ch0 write, `chk_err_i`=1 → `rsp_err_o[0]`=1 for exactly one cycle; all other `rsp_*` outputs stay 0.
- **Round-robin:** all three channels request continuously from reset → grants 0,1,2,0 at cycles 0,3,6,9.
- **Wrap:** `rr_ptr`=2 after serving ch1, with ch0 and ch2 valid → ch2 is granted, then ch0.
- **Latency:** `CheckLatency`=4 → `chk_valid_o` high for 4 cycles, response at T+5, `chk_err_i` sampled in the last `CHECK` cycle only.
- **Reset mid-check:** assert `rst` in `CHECK` → all outputs 0 immediately; after release, a new ch0 request is granted with `rr_ptr`=0.

Source files
------------

// File: rtl/iopmp_pkg.sv
// Shared IOPMP types: access kinds, arbiter FSM states and index-width helper.
package iopmp_pkg;

  localparam int unsigned SourceWidth = 8;

  typedef enum logic [1:0] {
    Read  = 2'b00,
    Write = 2'b01,
    Exec  = 2'b10
  } iopmp_req_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    RESP  = 2'b10
  } iopmp_arb_state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iopmp_rr_picker.sv
// Combinational round-robin picker: first valid index at or above ptr, wrapping.
module iopmp_rr_picker
  import iopmp_pkg::*;
#(
  parameter int unsigned NumReq   = 3,
  parameter int unsigned IdxWidth = idx_width(NumReq)
) (
  input  logic [NumReq-1:0]   valid,
  input  logic [IdxWidth-1:0] ptr,
  output logic [IdxWidth-1:0] grant,
  output logic                any_valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path infers a latch.
    grant     = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      logic [IdxWidth-1:0] idx;
      idx = IdxWidth'((32'(ptr) + i) % NumReq);
      if (!any_valid && valid[idx]) begin
        any_valid = 1'b1;
        grant     = idx;
      end
    end
  end

endmodule

// File: rtl/iopmp_check_arbiter.sv
// Shares one IOPMP checker among several requesters: round-robin grant,
// fixed-latency check, registered verdict returned as a one-cycle pulse.
module iopmp_check_arbiter
  import iopmp_pkg::*;
#(
  parameter int unsigned IOPMPNumChan = 3,
  parameter int unsigned AddrWidth    = 34,
  parameter int unsigned RridWidth    = SourceWidth,
  parameter int unsigned CheckLatency = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [IOPMPNumChan-1:0]                 req_valid_i,
  output logic [IOPMPNumChan-1:0]                 req_ready_o,
  input  logic [IOPMPNumChan-1:0][AddrWidth-1:0]  req_addr_i,
  input  iopmp_req_e [IOPMPNumChan-1:0]           req_type_i,
  input  logic [IOPMPNumChan-1:0][RridWidth-1:0]  req_rrid_i,
  output logic [IOPMPNumChan-1:0]                 rsp_valid_o,
  output logic [IOPMPNumChan-1:0]                 rsp_err_o,
  output logic                                    chk_valid_o,
  output logic [AddrWidth-1:0]                    chk_addr_o,
  output iopmp_req_e                              chk_type_o,
  output logic [RridWidth-1:0]                    chk_rrid_o,
  input  logic                                    chk_err_i
);

  localparam int unsigned IdxWidth = idx_width(IOPMPNumChan);
  localparam int unsigned CntWidth = $clog2(CheckLatency + 1);
  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(CheckLatency - 1);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(IOPMPNumChan - 1);

  iopmp_arb_state_e      state_q, state_d;
  logic [IdxWidth-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxWidth-1:0]   gnt_q, gnt_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  iopmp_req_e            type_q, type_d;
  logic [RridWidth-1:0]  rrid_q, rrid_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [IdxWidth-1:0]     pick_idx;
  logic                    pick_any;
  logic [IOPMPNumChan-1:0] ready_raw;

  iopmp_rr_picker #(
    .NumReq   (IOPMPNumChan),
    .IdxWidth (IdxWidth)
  ) u_picker (
    .valid     (req_valid_i),
    .ptr       (rr_ptr_q),
    .grant     (pick_idx),
    .any_valid (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      addr_q   <= '0;
      type_q   <= Read;
      rrid_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      type_q   <= type_d;
      rrid_q   <= rrid_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    type_d      = type_q;
    rrid_d      = rrid_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    ready_raw   = '0;
    rsp_valid_o = '0;
    rsp_err_o   = '0;
    chk_valid_o = 1'b0;
    chk_addr_o  = '0;
    chk_type_o  = Read;
    chk_rrid_o  = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          ready_raw[pick_idx] = 1'b1;
          gnt_d   = pick_idx;
          addr_d  = req_addr_i[pick_idx];
          type_d  = req_type_i[pick_idx];
          rrid_d  = req_rrid_i[pick_idx];
          cnt_d   = CntLoad;
          state_d = CHECK;
        end
      end
      CHECK: begin
        chk_valid_o = 1'b1;
        chk_addr_o  = addr_q;
        chk_type_o  = type_q;
        chk_rrid_o  = rrid_q;
        // Verdict is only trusted in the final cycle of the latency window.
        if (cnt_q == '0) begin
          err_d   = chk_err_i;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        rsp_valid_o[gnt_q] = 1'b1;
        rsp_err_o[gnt_q]   = err_q;
        rr_ptr_d = (gnt_q == LastIdx) ? '0 : gnt_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Keep the handshake silent while reset is held, even with requests pending.
  assign req_ready_o = ready_raw & {IOPMPNumChan{~rst}};

endmodule

// File: tb/tb_iopmp_check_arbiter.sv
// Self-checking bench: a latency-1 arbiter for grant/handshake behaviour and a
// latency-4 instance for the multi-cycle check window.
module tb_iopmp_check_arbiter;
  import iopmp_pkg::*;

  localparam int N  = 3;
  localparam int AW = 34;
  localparam int RW = SourceWidth;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]         v1, rdy1, rspv1, rspe1;
  logic [N-1:0][AW-1:0] addr1;
  iopmp_req_e [N-1:0]   typ1;
  logic [N-1:0][RW-1:0] rrid1;
  logic                 chkv1, cerr1;
  logic [AW-1:0]        chka1;
  iopmp_req_e           chkt1;
  logic [RW-1:0]        chkr1;

  logic [N-1:0]         v4, rdy4, rspv4, rspe4;
  logic [N-1:0][AW-1:0] addr4;
  iopmp_req_e [N-1:0]   typ4;
  logic [N-1:0][RW-1:0] rrid4;
  logic                 chkv4, cerr4;
  logic [AW-1:0]        chka4;
  iopmp_req_e           chkt4;
  logic [RW-1:0]        chkr4;

  iopmp_check_arbiter #(.IOPMPNumChan(N), .AddrWidth(AW), .RridWidth(RW), .CheckLatency(1)) dut (
    .clk(clk), .rst(rst), .req_valid_i(v1), .req_ready_o(rdy1), .req_addr_i(addr1),
    .req_type_i(typ1), .req_rrid_i(rrid1), .rsp_valid_o(rspv1), .rsp_err_o(rspe1),
    .chk_valid_o(chkv1), .chk_addr_o(chka1), .chk_type_o(chkt1), .chk_rrid_o(chkr1),
    .chk_err_i(cerr1)
  );

  iopmp_check_arbiter #(.IOPMPNumChan(N), .AddrWidth(AW), .RridWidth(RW), .CheckLatency(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid_i(v4), .req_ready_o(rdy4), .req_addr_i(addr4),
    .req_type_i(typ4), .req_rrid_i(rrid4), .rsp_valid_o(rspv4), .rsp_err_o(rspe4),
    .chk_valid_o(chkv4), .chk_addr_o(chka4), .chk_type_o(chkt4), .chk_rrid_o(chkr4),
    .chk_err_i(cerr4)
  );

  typedef struct {
    int               chan;
    logic [AW-1:0]    addr;
    iopmp_req_e       typ;
    logic [RW-1:0]    rrid;
    logic             verdict;
    logic [N-1:0]     exp_ready;
    logic [N-1:0]     exp_err;
  } vec_t;

  typedef struct {
    logic [N-1:0]     onehot;
    logic [N-1:0]     rsp_err;
    logic             verdict;
    logic [AW-1:0]    addr;
    iopmp_req_e       typ;
    logic [RW-1:0]    rrid;
    int               exp_acc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  vec_t tbl[6];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc[2];
  int   chk_cnt[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input int c, input logic [AW-1:0] a, input iopmp_req_e t,
                              input logic [RW-1:0] r, input logic verdict);
    vec_t v;
    v.chan      = c;
    v.addr      = a;
    v.typ       = t;
    v.rrid      = r;
    v.verdict   = verdict;
    v.exp_ready = N'(1) << c;
    v.exp_err   = verdict ? v.exp_ready : '0;
    return v;
  endfunction

  task automatic raise(input int d, input vec_t v, input int exp_acc);
    exp_t e;
    logic [1:0] ci;
    ci        = 2'(v.chan);
    e.onehot  = v.exp_ready;
    e.rsp_err = v.exp_err;
    e.verdict = v.verdict;
    e.addr    = v.addr;
    e.typ     = v.typ;
    e.rrid    = v.rrid;
    e.exp_acc = exp_acc;
    if (d == 0) begin
      v1[ci] = 1'b1; addr1[ci] = v.addr; typ1[ci] = v.typ; rrid1[ci] = v.rrid;
      q1.push_back(e);
    end else begin
      v4[ci] = 1'b1; addr4[ci] = v.addr; typ4[ci] = v.typ; rrid4[ci] = v.rrid;
      q4.push_back(e);
    end
  endtask

  task automatic mon(input int d, input logic [N-1:0] rdy, input logic [N-1:0] rspv,
                     input logic [N-1:0] rspe, input logic chkv, input logic [AW-1:0] chka,
                     input iopmp_req_e chkt, input logic [RW-1:0] chkr, input int lat);
    exp_t  f;
    bit    has;
    string p;
    p   = (d == 0) ? "lat1" : "lat4";
    has = (d == 0) ? (q1.size() != 0) : (q4.size() != 0);
    if (has) f = (d == 0) ? q1[0] : q4[0];

    if (rdy != '0) begin
      if (!has) check({p, "_unexpected_ready"}, 64'(rdy), 64'(0));
      else begin
        check({p, "_ready"}, 64'(rdy), 64'(f.onehot));
        if (f.exp_acc >= 0) check({p, "_accept_cycle"}, 64'(cyc), 64'(f.exp_acc));
        acc_cyc[d] = cyc;
        chk_cnt[d] = 0;
      end
    end

    if (chkv) begin
      chk_cnt[d]++;
      if (!has) check({p, "_unexpected_chk"}, 64'(chkv), 64'(0));
      else check({p, "_chk_payload"}, 64'({chka, chkt, chkr}), 64'({f.addr, f.typ, f.rrid}));
    end else begin
      check({p, "_chk_idle_zero"}, 64'({chka, chkt, chkr}), 64'(0));
    end

    if (rspv != '0 || rspe != '0) begin
      if (!has) check({p, "_unexpected_rsp"}, 64'({rspv, rspe}), 64'(0));
      else begin
        check({p, "_rsp"}, 64'({rspv, rspe}), 64'({f.onehot, f.rsp_err}));
        check({p, "_rsp_cycle"}, 64'(cyc), 64'(acc_cyc[d] + lat + 1));
        check({p, "_chk_cycles"}, 64'(chk_cnt[d]), 64'(lat));
        if (d == 0) void'(q1.pop_front());
        else void'(q4.pop_front());
      end
    end
  endtask

  // One clock: sample at negedge, then update stimulus just after posedge.
  task automatic step();
    logic [N-1:0] s1, s4;
    @(negedge clk);
    s1 = rdy1;
    s4 = rdy4;
    mon(0, rdy1, rspv1, rspe1, chkv1, chka1, chkt1, chkr1, 1);
    mon(1, rdy4, rspv4, rspe4, chkv4, chka4, chkt4, chkr4, 4);
    @(posedge clk);
    cyc++;
    #1;
    v1 = v1 & ~s1;
    v4 = v4 & ~s4;
    // Drive the true verdict only in the last check cycle, its inverse otherwise.
    if (q1.size() != 0) cerr1 = chkv1 ? q1[0].verdict : ~q1[0].verdict;
    else cerr1 = 1'b1;
    if (q4.size() != 0) cerr4 = (chkv4 && chk_cnt[1] + 1 == 4) ? q4[0].verdict : ~q4[0].verdict;
    else cerr4 = 1'b1;
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(q1.size() + q4.size()), 64'(0));
    q1.delete();
    q4.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    v1 = '0; v4 = '0; addr1 = '0; addr4 = '0; rrid1 = '0; rrid4 = '0;
    for (int i = 0; i < N; i++) begin
      typ1[i] = Read;
      typ4[i] = Read;
    end
    cerr1 = 1'b0; cerr4 = 1'b0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; chk_cnt[0] = 0; chk_cnt[1] = 0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_lat1", 64'({rdy1, rspv1, rspe1, chkv1, chka1, chkt1, chkr1}), 64'(0));
    check("reset_outputs_lat4", 64'({rdy4, rspv4, rspe4, chkv4, chka4, chkt4, chkr4}), 64'(0));
    @(posedge clk); #1; rst = 1'b0; cyc = 0;

    // Single-requester vectors, applied back to back.
    tbl[0] = '{1, 34'h0_0000_1000, Read,  8'h11, 1'b0, 3'b010, 3'b000};
    tbl[1] = '{0, 34'h2_0000_0040, Write, 8'h22, 1'b1, 3'b001, 3'b001};
    tbl[2] = '{2, 34'h3_ffff_fffc, Exec,  8'hff, 1'b0, 3'b100, 3'b000};
    tbl[3] = '{2, 34'h0_0000_0000, Read,  8'h00, 1'b1, 3'b100, 3'b100};
    tbl[4] = '{0, 34'h1_2345_6789, Read,  8'h5a, 1'b0, 3'b001, 3'b000};
    tbl[5] = '{1, 34'h0_dead_beec, Write, 8'ha5, 1'b1, 3'b010, 3'b010};
    for (int i = 0; i < 6; i++) begin
      raise(0, tbl[i], cyc);
      run_until_empty(20);
    end

    // Wrap: pointer now 2, so ch2 wins over ch0.
    raise(0, mk(2, 34'h0_0000_2200, Write, 8'h02, 1'b0), cyc);
    raise(0, mk(0, 34'h0_0000_0400, Exec,  8'h40, 1'b1), cyc + 3);
    run_until_empty(20);

    // Round-robin from reset with all three requesting.
    @(posedge clk); #1; rst = 1'b1;
    raise(0, mk(0, 34'h0_0000_a000, Read,  8'h10, 1'b0), 0);
    raise(0, mk(1, 34'h0_0000_b000, Write, 8'h20, 1'b1), 3);
    raise(0, mk(2, 34'h0_0000_c000, Exec,  8'h30, 1'b0), 6);
    @(negedge clk);
    check("ready_held_in_reset", 64'(rdy1), 64'(0));
    @(posedge clk); #1; rst = 1'b0; cyc = 0;
    repeat (3) step();
    raise(0, mk(0, 34'h0_0000_a004, Write, 8'h11, 1'b1), 9);
    run_until_empty(40);

    // Four-cycle checker window.
    raise(1, mk(0, 34'h1_0000_0000, Read,  8'h01, 1'b0), cyc);
    run_until_empty(20);
    raise(1, mk(2, 34'h2_0000_0008, Write, 8'h7e, 1'b1), cyc);
    run_until_empty(20);
    raise(1, mk(1, 34'h0_0000_0010, Exec,  8'h33, 1'b0), cyc);
    run_until_empty(20);

    // Reset during CHECK: transaction dropped, pointer back to 0.
    raise(0, mk(1, 34'h0_0000_5000, Read, 8'h51, 1'b0), cyc);
    run_until_empty(20);
    raise(0, mk(2, 34'h0_0000_6000, Write, 8'h62, 1'b1), cyc);
    begin
      int n = 0;
      while (!chkv1 && n < 5) begin
        step();
        n++;
      end
    end
    check("reached_check", 64'(chkv1), 64'(1));
    rst = 1'b1;
    q1.delete();
    v1 = '0;
    raise(0, mk(0, 34'h0_0000_7000, Read, 8'h70, 1'b1), 0);
    raise(0, mk(2, 34'h0_0000_8000, Exec, 8'h80, 1'b0), 3);
    #1;
    check("reset_mid_check_outputs", 64'({rdy1, rspv1, rspe1, chkv1, chka1, chkt1, chkr1}), 64'(0));
    @(posedge clk); #1; rst = 1'b0; cyc = 0;
    run_until_empty(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
